// File: rtl/ex_pkg.sv
// Execute-stage encodings, divider FSM states and shared helpers.
package ex_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned SEL_W = 3;

  // aluop_i encodings
  localparam logic [OP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [OP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [OP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [OP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [OP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [OP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [OP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [OP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [OP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [OP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [OP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [OP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [OP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  // alusel_i result classes
  localparam logic [SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [SEL_W-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [SEL_W-1:0] EXE_RES_ARITH = 3'b100;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_ON  = 2'd1,
    DIV_END = 2'd2
  } div_state_e;

  // True for either divide opcode.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied in DIV_END. flush aborts immediately and beats start.
module div_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] dvd_q;   // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic              q_neg_q;
  logic              r_neg_q;

  logic              a_neg, b_neg, div_zero;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   shifted, diff;
  logic              load, step;

  assign a_neg    = signed_op & a[DATA_W-1];
  assign b_neg    = signed_op & b[DATA_W-1];
  assign a_abs    = a_neg ? -a : a;
  assign b_abs    = b_neg ? -b : b;
  assign div_zero = (b == '0);

  // Partial remainder with next dividend bit, and trial subtraction.
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy    = 1'b1;
            load    = 1'b1;
            state_d = div_zero ? DIV_END : DIV_ON;
          end
        end
        DIV_ON: begin
          busy = 1'b1;
          step = 1'b1;
          if (count_q == CNT_LAST) state_d = DIV_END;
        end
        DIV_END: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand latch and shift-subtract datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      count_q <= '0;
      if (div_zero) begin
        dvd_q   <= '1;
        dvs_q   <= '0;
        rem_q   <= a;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end else begin
        dvd_q   <= a_abs;
        dvs_q   <= b_abs;
        rem_q   <= '0;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
      end
    end else if (step) begin
      count_q <= count_q + CNT_W'(1);
      if (!diff[DATA_W]) begin
        rem_q <= diff[DATA_W-1:0];
        dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_q <= shifted[DATA_W-1:0];
        dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign quot = q_neg_q ? -dvd_q : dvd_q;
  assign rem  = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: logic/shift/arith/move units, single-cycle multiply,
// HI/LO registers and an iterative divider that stalls the pipeline.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 8,
  parameter int unsigned ALUSEL_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stall_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   logic_res, shift_res, arith_res, move_res, result;
  logic [2*DATA_W-1:0] prod;
  logic [SH_W-1:0]     shamt;
  logic                is_div, is_mult_s, ext_a, ext_b, wr_ok;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   div_quot, div_rem;

  assign shamt     = reg2_i[SH_W-1:0];
  assign is_div    = is_div_op(OP_W'(aluop_i));
  assign is_mult_s = (aluop_i == ALUOP_W'(EXE_MULT_OP));
  assign wr_ok     = valid_i & ~flush_i;

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (valid_i & is_div),
    .signed_op (aluop_i == ALUOP_W'(EXE_DIV_OP)),
    .flush     (flush_i),
    .a         (reg1_i),
    .b         (reg2_i),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  // Logic unit.
  always_comb begin
    logic_res = '0;
    case (aluop_i)
      ALUOP_W'(EXE_OR_OP):  logic_res = reg1_i | reg2_i;
      ALUOP_W'(EXE_AND_OP): logic_res = reg1_i & reg2_i;
      ALUOP_W'(EXE_XOR_OP): logic_res = reg1_i ^ reg2_i;
      ALUOP_W'(EXE_NOR_OP): logic_res = ~(reg1_i | reg2_i);
      default:              logic_res = '0;
    endcase
  end

  // Shift unit.
  always_comb begin
    shift_res = '0;
    case (aluop_i)
      ALUOP_W'(EXE_SLL_OP): shift_res = reg1_i << shamt;
      ALUOP_W'(EXE_SRL_OP): shift_res = reg1_i >> shamt;
      ALUOP_W'(EXE_SRA_OP): shift_res = $unsigned($signed(reg1_i) >>> shamt);
      default:              shift_res = '0;
    endcase
  end

  // Add/sub and set-less-than.
  always_comb begin
    arith_res = '0;
    case (aluop_i)
      ALUOP_W'(EXE_ADDU_OP): arith_res = reg1_i + reg2_i;
      ALUOP_W'(EXE_SUBU_OP): arith_res = reg1_i - reg2_i;
      ALUOP_W'(EXE_SLT_OP):  arith_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
      ALUOP_W'(EXE_SLTU_OP): arith_res = DATA_W'(reg1_i < reg2_i);
      default:               arith_res = '0;
    endcase
  end

  // HI/LO reads return the registered value, never the same-edge write.
  always_comb begin
    move_res = '0;
    case (aluop_i)
      ALUOP_W'(EXE_MFHI_OP): move_res = hi_q;
      ALUOP_W'(EXE_MFLO_OP): move_res = lo_q;
      default:               move_res = '0;
    endcase
  end

  // One multiplier; operand extension chooses signed or unsigned product.
  assign ext_a = is_mult_s & reg1_i[DATA_W-1];
  assign ext_b = is_mult_s & reg2_i[DATA_W-1];
  assign prod  = {{DATA_W{ext_a}}, reg1_i} * {{DATA_W{ext_b}}, reg2_i};

  // Result class mux.
  always_comb begin
    result = '0;
    case (alusel_i)
      ALUSEL_W'(EXE_RES_LOGIC): result = logic_res;
      ALUSEL_W'(EXE_RES_SHIFT): result = shift_res;
      ALUSEL_W'(EXE_RES_ARITH): result = arith_res;
      ALUSEL_W'(EXE_RES_MOVE):  result = move_res;
      default:                  result = '0;
    endcase
  end

  // HI/LO registers: divide completion, multiply and explicit moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done & wr_ok) begin
      hi_q <= div_rem;
      lo_q <= div_quot;
    end else if (wr_ok) begin
      case (aluop_i)
        ALUOP_W'(EXE_MULT_OP),
        ALUOP_W'(EXE_MULTU_OP): {hi_q, lo_q} <= prod;
        ALUOP_W'(EXE_MTHI_OP):  hi_q <= reg1_i;
        ALUOP_W'(EXE_MTLO_OP):  lo_q <= reg1_i;
        default: ;
      endcase
    end
  end

  assign stall_o = ~rst & div_busy;
  assign wd_o    = rst ? '0 : wd_i;
  assign wreg_o  = ~rst & wreg_i & valid_i & ~stall_o & ~is_div;
  assign wdata_o = rst ? DATA_W'(ZERO_WORD) : result;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule
